// File: rtl/picorv32_mem_pkg.sv
// rtl/picorv32_mem_pkg.sv - shared constants for the picorv32 memory responder
package picorv32_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Fibonacci taps 16,14,13,11 expressed as a mask over state[15:0]
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam logic [31:0] DEFAULT_OOB_RDATA = 32'h0000_0000;

endpackage

// File: rtl/picorv32_mem_lfsr.sv
// rtl/picorv32_mem_lfsr.sv - 16-bit Fibonacci LFSR used for random wait-state jitter
module picorv32_mem_lfsr
  import picorv32_mem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic [15:0] state
);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= LFSR_SEED;
    end else if (enable) begin
      state <= {state[14:0], ^(state & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/picorv32_mem_responder.sv
// rtl/picorv32_mem_responder.sv - picorv32 native-bus RAM responder with wait states
// Optional MEMRESP_RANDOM_WAIT_EN adds LFSR-driven 0..3 extra wait states per request.
module picorv32_mem_responder
  import picorv32_mem_pkg::*;
#(
  parameter int unsigned MEM_WORDS   = 1024,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] OOB_RDATA   = DEFAULT_OOB_RDATA
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        err_oob,
  output logic [31:0] err_addr,
  output logic [15:0] fetch_cnt
);

  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  logic [31:0] mem [MEM_WORDS];

  state_t      state, state_next;
  logic [4:0]  cnt, cnt_next, w_eff;
  logic        accept;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  wstrb_q;
  logic        instr_q;
  logic [31:0] req_addr, req_idx;
  logic [3:0]  req_wstrb;
  logic        req_oob;

`ifdef MEMRESP_RANDOM_WAIT_EN
  logic [15:0] lfsr;

  picorv32_mem_lfsr u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .enable (accept),
    .state  (lfsr)
  );

  assign w_eff = 5'(WAIT_STATES) + {3'b000, lfsr[1:0]};
`else
  assign w_eff = 5'(WAIT_STATES);
`endif

  // In IDLE the live bus is decoded so a zero-wait read can load rdata on the accept edge
  assign req_addr  = (state == IDLE) ? mem_addr  : addr_q;
  assign req_wstrb = (state == IDLE) ? mem_wstrb : wstrb_q;
  assign req_idx   = (req_addr - ADDR_BASE) >> 2;
  assign req_oob   = (req_idx >= MEM_WORDS);

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (mem_valid) begin
          accept     = 1'b1;
          cnt_next   = w_eff;
          state_next = (w_eff == 5'd0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (!mem_valid) begin
          state_next = IDLE;
        end else if (cnt == 5'd1) begin
          state_next = RESP;
        end else begin
          cnt_next = cnt - 5'd1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  assign mem_ready = (state == RESP) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= 5'd0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      wstrb_q   <= 4'd0;
      instr_q   <= 1'b0;
      mem_rdata <= 32'd0;
      err_oob   <= 1'b0;
      err_addr  <= 32'd0;
      fetch_cnt <= 16'd0;
    end else begin
      cnt <= cnt_next;
      if (accept) begin
        addr_q  <= mem_addr;
        wdata_q <= mem_wdata;
        wstrb_q <= mem_wstrb;
        instr_q <= mem_instr;
      end
      if (state_next == RESP && req_wstrb == 4'd0) begin
        mem_rdata <= req_oob ? OOB_RDATA : mem[req_idx[AW-1:0]];
      end
      if (state == RESP) begin
        if (req_oob) begin
          err_oob <= 1'b1;
          if (!err_oob) err_addr <= addr_q;
        end
        if (instr_q && wstrb_q == 4'd0) fetch_cnt <= fetch_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && state == RESP && !req_oob) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) mem[req_idx[AW-1:0]][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_picorv32_mem_responder.sv
// tb/tb_picorv32_mem_responder.sv - directed bench for picorv32_mem_responder
module tb_picorv32_mem_responder;

`ifdef MEMRESP_RANDOM_WAIT_EN
  localparam int unsigned WS_B = 1;
`else
  localparam int unsigned WS_B = 3;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid_a = 1'b0, valid_b = 1'b0;
  logic        instr = 1'b0;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic [3:0]  wstrb = 4'd0;
  logic        ready_a, ready_b, oob_a, oob_b;
  logic [31:0] rdata_a, rdata_b, eaddr_a, eaddr_b;
  logic [15:0] fcnt_a, fcnt_b;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_ready_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  picorv32_mem_responder #(
    .MEM_WORDS(1024), .ADDR_BASE(32'h0), .WAIT_STATES(0), .OOB_RDATA(32'hDEAD_0BB0)
  ) u_a (
    .clk(clk), .reset(reset), .mem_valid(valid_a), .mem_instr(instr),
    .mem_addr(addr), .mem_wdata(wdata), .mem_wstrb(wstrb),
    .mem_ready(ready_a), .mem_rdata(rdata_a), .err_oob(oob_a),
    .err_addr(eaddr_a), .fetch_cnt(fcnt_a)
  );

  picorv32_mem_responder #(
    .MEM_WORDS(1024), .ADDR_BASE(32'h0), .WAIT_STATES(WS_B), .OOB_RDATA(32'h0)
  ) u_b (
    .clk(clk), .reset(reset), .mem_valid(valid_b), .mem_instr(instr),
    .mem_addr(addr), .mem_wdata(wdata), .mem_wstrb(wstrb),
    .mem_ready(ready_b), .mem_rdata(rdata_b), .err_oob(oob_b),
    .err_addr(eaddr_b), .fetch_cnt(fcnt_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic rdy(input int which);
    return (which == 0) ? ready_a : ready_b;
  endfunction

  // One transfer, starting with the DUT idle; returns cycles to mem_ready and rdata.
  task automatic xfer(input int which, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic ins,
                      output int lat, output logic [31:0] rd);
    addr = a; wdata = d; wstrb = s; instr = ins;
    if (which == 0) valid_a = 1'b1; else valid_b = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!rdy(which) && lat < 40);
    chk("ready_seen", {31'd0, rdy(which)}, 32'd1);
    rd = (which == 0) ? rdata_a : rdata_b;
    last_ready_cyc = cyc;
    valid_a = 1'b0; valid_b = 1'b0;
    @(posedge clk); #1;
    chk("ready_one_cycle", {31'd0, rdy(which)}, 32'd0);
  endtask

  int          lat;
  int          c0;
  logic [31:0] rd;

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_ready", {31'd0, ready_a}, 32'd0);
    chk("rst_rdata", rdata_a, 32'd0);
    chk("rst_oob", {31'd0, oob_a}, 32'd0);
    chk("rst_eaddr", eaddr_a, 32'd0);
    chk("rst_fcnt", {16'd0, fcnt_a}, 32'd0);

`ifdef MEMRESP_RANDOM_WAIT_EN
    xfer(1, 32'h40, 32'h1357_9BDF, 4'hF, 1'b0, lat, rd);
    for (int i = 0; i < 100; i++) begin
      xfer(1, 32'h40, 32'h0, 4'h0, 1'b1, lat, rd);
      chk("rand_lat_range", {31'd0, (lat >= 2 && lat <= 5)}, 32'd1);
      chk("rand_rdata", rd, 32'h1357_9BDF);
    end
    chk("rand_fcnt", {16'd0, fcnt_b}, 32'd100);
`else
    // zero wait states: write then read back
    xfer(0, 32'h10, 32'hCAFE_F00D, 4'hF, 1'b0, lat, rd);
    chk("w0_wr_lat", lat, 1);
    c0 = last_ready_cyc;
    xfer(0, 32'h10, 32'h0, 4'h0, 1'b0, lat, rd);
    chk("w0_rd_lat", lat, 1);
    chk("w0_rd_data", rd, 32'hCAFE_F00D);
    chk("w0_spacing", last_ready_cyc - c0, 2);

    // byte lanes
    xfer(0, 32'h20, 32'h1122_3344, 4'hF, 1'b0, lat, rd);
    xfer(0, 32'h20, 32'h0, 4'h0, 1'b0, lat, rd);
    chk("lane_pre", rd, 32'h1122_3344);
    xfer(0, 32'h20, 32'hAABB_CCDD, 4'b0101, 1'b0, lat, rd);
    chk("lane_rdata_held", rd, 32'h1122_3344);
    xfer(0, 32'h20, 32'h0, 4'h0, 1'b0, lat, rd);
    chk("lane_merge", rd, 32'h11BB_33DD);

    // fetch counting: instruction reads only
    xfer(0, 32'h10, 32'h0, 4'h0, 1'b1, lat, rd);
    chk("fcnt_fetch", {16'd0, fcnt_a}, 32'd1);
    xfer(0, 32'h24, 32'h5, 4'hF, 1'b1, lat, rd);
    chk("fcnt_instr_write", {16'd0, fcnt_a}, 32'd1);

    // range boundaries
    xfer(0, 32'h0, 32'h0102_0304, 4'hF, 1'b0, lat, rd);
    xfer(0, 32'hFFC, 32'h5A5A_5A5A, 4'hF, 1'b0, lat, rd);
    xfer(0, 32'hFFC, 32'h0, 4'h0, 1'b0, lat, rd);
    chk("last_word", rd, 32'h5A5A_5A5A);
    chk("last_word_no_oob", {31'd0, oob_a}, 32'd0);
    xfer(0, 32'h1000, 32'h0, 4'h0, 1'b0, lat, rd);
    chk("oob_rdata", rd, 32'hDEAD_0BB0);
    chk("oob_lat", lat, 1);
    chk("oob_flag", {31'd0, oob_a}, 32'd1);
    chk("oob_eaddr", eaddr_a, 32'h1000);
    xfer(0, 32'h1000, 32'hFFFF_FFFF, 4'hF, 1'b0, lat, rd);
    xfer(0, 32'h2000, 32'hFFFF_FFFF, 4'hF, 1'b0, lat, rd);
    chk("oob2_eaddr_kept", eaddr_a, 32'h1000);
    xfer(0, 32'h0, 32'h0, 4'h0, 1'b0, lat, rd);
    chk("oob_no_alias", rd, 32'h0102_0304);

    // three wait states
    xfer(1, 32'h10, 32'h0000_0077, 4'hF, 1'b0, lat, rd);
    chk("w3_wr_lat", lat, 4);
    c0 = last_ready_cyc;
    xfer(1, 32'h10, 32'h0, 4'h0, 1'b0, lat, rd);
    chk("w3_rd_lat", lat, 4);
    chk("w3_rd_data", rd, 32'h0000_0077);
    chk("w3_spacing", last_ready_cyc - c0, 5);

    // reset while a write is waiting
    xfer(1, 32'h30, 32'h0BAD_BEEF, 4'hF, 1'b0, lat, rd);
    addr = 32'h30; wdata = 32'h1234_5678; wstrb = 4'hF; instr = 1'b0;
    valid_b = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_wait_ready", {31'd0, ready_b}, 32'd0);
    reset = 1'b1; valid_b = 1'b0;
    @(posedge clk); #1;
    chk("abort_ready", {31'd0, ready_b}, 32'd0);
    chk("abort_rdata", rdata_b, 32'd0);
    chk("abort_fcnt_a", {16'd0, fcnt_a}, 32'd0);
    chk("abort_oob_a", {31'd0, oob_a}, 32'd0);
    chk("abort_eaddr_a", eaddr_a, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("abort_no_ready", {31'd0, ready_b}, 32'd0);
    end
    xfer(1, 32'h30, 32'h0, 4'h0, 1'b0, lat, rd);
    chk("abort_ram_kept", rd, 32'h0BAD_BEEF);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/picorv32_mem_responder.md
Name: picorv32_mem_responder

Overview:
- Synchronous on-chip RAM that acts as the responder end of the picorv32 native memory interface.
- Accepts the core's mem_valid/mem_addr/mem_wdata/mem_wstrb requests and returns mem_ready/mem_rdata after a configurable number of wait states.
- Sits beside the core in gate-level and synthesis test tops. Replaces behavioural testbench memories so the core is exercised against real handshake timing.
- Holds mem_rdata stable between reads, so it directly serves a core built with LATCHED_MEM_RDATA=1.

Parameters:
- MEM_WORDS, 1024, RAM depth in 32-bit words.
- ADDR_BASE, 32'h0000_0000, byte address of word 0; must be word aligned.
- WAIT_STATES, 0, idle cycles between request acceptance and mem_ready (0..15).
- OOB_RDATA, 32'h0000_0000, read value for out-of-range addresses.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_valid  in  1  request valid, held by core until mem_ready.
- mem_instr  in  1  request is an instruction fetch (statistics only).
- mem_addr  in  32  byte address; bits [1:0] ignored.
- mem_wdata  in  32  write data.
- mem_wstrb  in  4  byte-lane write enables; 0 = read.
- mem_ready  out  1  one-cycle completion pulse.
- mem_rdata  out  32  read data, held until the next read completes.
- err_oob  out  1  sticky: an out-of-range access occurred.
- err_addr  out  32  mem_addr of the first out-of-range access.
- fetch_cnt  out  16  count of completed mem_instr=1 reads, wraps at 0xFFFF.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - mem_ready=0, mem_rdata=0, err_oob=0, err_addr=0, fetch_cnt=0.
  - RAM contents are not cleared.
  - Reset during WAIT or RESP aborts the transfer: no write, no ready.
- State machine:
  - IDLE -> accept when mem_valid=1. Capture addr, wdata, wstrb and instr. Load wait counter with the effective wait count W. Go to RESP if W=0, else WAIT.
  - WAIT: decrement counter; go to RESP when it reaches 1.
  - If mem_valid falls in WAIT (protocol violation): return to IDLE with no write and no ready.
  - RESP: mem_ready=1 for exactly this one cycle, then IDLE.
- Latency: mem_ready rises W+1 cycles after the first IDLE cycle with mem_valid=1. W=0 gives ready on the next cycle.
- Back-to-back transfers:
  - The core drops or changes mem_valid on the edge that samples mem_ready.
  - The IDLE cycle after RESP may accept a new request.
  - Minimum spacing is 2 cycles per transfer.
- Index computation: index = (addr - ADDR_BASE) >> 2, 32-bit unsigned subtraction. Addresses below ADDR_BASE wrap to huge values and are therefore out of range.
- In-range read: mem_rdata updates to RAM[index] on the cycle mem_ready is high.
- In-range write:
  - Lane i of RAM[index] is written from wdata[8i+7:8i] when wstrb[i]=1, on the RESP edge.
  - mem_rdata is unchanged by writes.
  - A read in the next transfer returns the new data.
- Out-of-range access (index >= MEM_WORDS):
  - The transfer still completes, so the core never hangs.
  - A read returns OOB_RDATA; a write is dropped.
  - err_oob sets; err_addr latches only if err_oob was 0.
- fetch_cnt increments in RESP when the captured instr=1 and wstrb=0.

Optional Feature:
- MEMRESP_RANDOM_WAIT_EN defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances once per accepted request.
  - Effective W = WAIT_STATES + lfsr[1:0].
- Undefined: W = WAIT_STATES and no LFSR logic is present.

Decomposition:
- Shared package picorv32_mem_pkg holds:
  - state encoding constants IDLE/WAIT/RESP;
  - LFSR seed and tap mask;
  - the default OOB_RDATA value.
- One sub-module, picorv32_mem_lfsr (enable, reset, 16-bit state out), instantiated only under MEMRESP_RANDOM_WAIT_EN.

Test Plan:
- WAIT_STATES=0: write 32'hCAFEF00D to 0x10 with wstrb=4'hF, then read 0x10 -> each mem_ready arrives 1 cycle after mem_valid; rdata=32'hCAFEF00D.
- Byte lanes: preload 0x11223344 at 0x20, write wdata=0xAABBCCDD with wstrb=4'b0101, then read -> 0x11BB33DD; rdata from the earlier read is unchanged during the write.
- WAIT_STATES=3: read -> mem_ready high exactly 4 cycles after mem_valid, low otherwise; back-to-back reads spaced 5 cycles.
- Out-of-range: read 4*MEM_WORDS -> rdata=OOB_RDATA, err_oob=1, err_addr=0x1000; a second out-of-range access at 0x2000 leaves err_addr=0x1000.
- Reset asserted in WAIT of a write to 0x30 -> no mem_ready; RAM[12] unchanged; outputs zero next cycle.
- MEMRESP_RANDOM_WAIT_EN, WAIT_STATES=1: 100 fetches with mem_instr=1 -> latencies within 2..5; fetch_cnt=100.
